// File: rtl/car_sense.sv
// car_sense: loop-detector front end (sync, 1 ms tick, debounce) plus request handshake FSM.
// Define CAR_COUNT_EN to add an 8-bit car_count output counting issued requests.
module car_sense #(
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter int unsigned STUCK_MS    = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_raw,
  input  logic       ew_green,
  output logic       car,
  output logic       present,
  output logic       fault
`ifdef CAR_COUNT_EN
  ,
  output logic [7:0] car_count
`endif
);

  localparam int unsigned TickW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DebW   = (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS + 1) : 1;
  localparam int unsigned StuckW = (STUCK_MS > 1) ? $clog2(STUCK_MS + 1) : 1;

  localparam logic [TickW-1:0]  TickMax  = TickW'(TICK_DIV - 1);
  localparam logic [DebW-1:0]   DebLast  = DebW'(DEBOUNCE_MS - 1);
  localparam logic [StuckW-1:0] StuckMax = StuckW'(STUCK_MS);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StServe,
    StFault
  } state_e;

  logic              sync_meta_q;
  logic              sync_q;
  logic [TickW-1:0]  tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [DebW-1:0]   deb_cnt_q, deb_cnt_d;
  logic              present_q, present_d;
  logic [StuckW-1:0] stuck_cnt_q, stuck_cnt_d;
  logic              stuck_hit;
  state_e            state_q, state_d;

  // Tick prescaler
  always_comb begin
    tick       = (tick_cnt_q == TickMax);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
  end

  // Debounce: a mismatch must survive DEBOUNCE_MS ticks; any agreement restarts it.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    present_d = present_q;
    if (sync_q == present_q) begin
      deb_cnt_d = '0;
    end else if (tick) begin
      if (deb_cnt_q == DebLast) begin
        present_d = sync_q;
        deb_cnt_d = '0;
      end else begin
        deb_cnt_d = deb_cnt_q + DebW'(1);
      end
    end
  end

  // Stuck detector; stuck_hit marks only the cycle the saturation value is reached.
  always_comb begin
    stuck_cnt_d = stuck_cnt_q;
    if (!present_q) begin
      stuck_cnt_d = '0;
    end else if (tick && (stuck_cnt_q != StuckMax)) begin
      stuck_cnt_d = stuck_cnt_q + StuckW'(1);
    end
    stuck_hit = (stuck_cnt_d == StuckMax) && (stuck_cnt_q != StuckMax);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (present_q) begin
          state_d = ew_green ? StServe : StReq;
        end
      end
      StReq: begin
        if (ew_green) begin
          state_d = StServe;
        end
      end
      StServe: begin
        if (!ew_green) begin
          state_d = StIdle;
        end
      end
      StFault: begin
        if (!present_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // Fault wins over any handshake transition in the same cycle
    if (stuck_hit) begin
      state_d = StFault;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      tick_cnt_q  <= '0;
      deb_cnt_q   <= '0;
      present_q   <= 1'b0;
      stuck_cnt_q <= '0;
      state_q     <= StIdle;
    end else begin
      sync_meta_q <= sensor_raw;
      sync_q      <= sync_meta_q;
      tick_cnt_q  <= tick_cnt_d;
      deb_cnt_q   <= deb_cnt_d;
      present_q   <= present_d;
      stuck_cnt_q <= stuck_cnt_d;
      state_q     <= state_d;
    end
  end

  assign car     = (state_q == StReq);
  assign fault   = (state_q == StFault);
  assign present = present_q;

`ifdef CAR_COUNT_EN
  logic [7:0] car_count_q;
  logic       new_request;

  assign new_request = (state_q == StIdle) && ((state_d == StReq) || (state_d == StServe));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      car_count_q <= 8'd0;
    end else if (new_request) begin
      car_count_q <= car_count_q + 8'd1;
    end
  end

  assign car_count = car_count_q;
`endif

endmodule

// File: doc/car_sense.md
CAR_SENSE -- requirements
Module: car_sense

Interface
REQ-001 The block SHALL take parameters, one per line: name, default, meaning.
- TICK_DIV, 50000, clk cycles per 1 ms tick (at least 2).
- DEBOUNCE_MS, 20, consecutive ticks a changed input must persist before it is accepted.
- STUCK_MS, 10000, ticks of continuous presence before the block declares a sensor fault.
REQ-002 The block SHALL have ports, one per line: name, direction, width, meaning.
- clk, in, 1, clock.
- reset, in, 1, reset: asynchronous, active-high.
- sensor_raw, in, 1, unsynchronised east/west loop-detector level.
- ew_green, in, 1, high while the intersection controller shows east/west green.
- car, out, 1, registered service request to the intersection controller.
- present, out, 1, debounced vehicle-presence level.
- fault, out, 1, stuck-sensor flag.

Function
REQ-003 sensor_raw SHALL pass through a 2-flop synchroniser; the synchronised value is sync.
REQ-004 A tick counter SHALL count 0..TICK_DIV-1 and wrap, pulsing tick for one cycle on wrap.
REQ-005 Debounce counter behaviour:
- Clears whenever sync equals present.
- Increments on each tick while sync differs from present.
- When it reaches DEBOUNCE_MS, present takes sync on that cycle and the counter clears.
REQ-006 The request FSM SHALL have states IDLE, REQ, SERVE and FAULT, all registered.
REQ-007 From IDLE:
- present=1 and ew_green=0 -> REQ.
- present=1 and ew_green=1 -> SERVE; car never asserts.
REQ-008 REQ SHALL drive car=1 and move to SERVE on the first cycle ew_green=1; car is 0 in every other state.
REQ-009 SERVE SHALL return to IDLE on the first cycle ew_green=0. If present is still 1, IDLE re-requests on the next cycle.
REQ-010 Stuck counter behaviour:
- Increments on tick while present=1.
- Clears when present=0.
- Saturates at STUCK_MS.
REQ-011 On the cycle the stuck counter reaches STUCK_MS, the FSM SHALL enter FAULT from any state. FAULT drives fault=1 and car=0.
REQ-012 FAULT SHALL exit to IDLE on the cycle after present falls to 0, clearing fault.
REQ-013 If the stuck-counter saturation and an ew_green edge occur in the same cycle, FAULT SHALL take priority.
REQ-014 A present rise SHALL assert car no later than 2 cycles after present changes.

Reset
REQ-015 While reset=1, the block SHALL hold:
- Synchroniser flops, present, car and fault at 0.
- All counters at 0.
- FSM in IDLE.
REQ-016 Reset SHALL apply immediately at any point, including mid-debounce or in REQ/FAULT. Operation resumes on the first clk edge after deassertion.

Configuration
REQ-017 With CAR_COUNT_EN defined:
- An extra output car_count, out, 8 bits, counts IDLE->REQ and IDLE->SERVE transitions.
- car_count wraps 255->0 and resets to 0.
REQ-018 Without CAR_COUNT_EN, the port and its counter SHALL be absent and all other behaviour is identical.

Verification (TICK_DIV=4, DEBOUNCE_MS=3, STUCK_MS=10)
REQ-019 Debounce acceptance: sensor_raw held 1 -> present=1 after exactly 3 ticks of mismatch plus 2 sync cycles; then car=1 within 2 cycles.
REQ-020 Glitch rejection: sensor_raw 1 for 2 ticks, then 0 -> present and car stay 0; debounce counter returns to 0.
REQ-021 Handshake: car=1, then ew_green=1 -> car=0 the next cycle. ew_green=0 with present=0 -> state IDLE, car stays 0.
REQ-022 Stuck sensor: present held 1 for 10 ticks -> fault=1 and car=0 regardless of ew_green. sensor_raw=0 debounced -> fault=0.
REQ-023 Already green: present rises while ew_green=1 -> car never asserts; ew_green falls with present=1 -> car=1.
REQ-024 Reset mid-REQ: reset pulsed while car=1 -> car, present, fault and car_count (if enabled) read 0 immediately. With CAR_COUNT_EN, 256 requests -> car_count=0.
